lap_duty_ramp: RTL
==================

// Module: lap_duty_ramp
// PURPOSE
//  Command stage feeding the locked-anti-phase H-bridge driver. Maps a signed speed command to a
//  PWM hi_time about mid-period (50% = zero current) and slew-limits it once per PWM period.
//  Sequences bridge enable so disabling ramps to 50% before the bridge is switched off.
// PARAMETERS
//  DWID  32  width of period / hi_time / step values
//  SWID  16  width of signed speed command (two's complement)
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous, active-high reset
//  i_run         in   1     1 = run motor, 0 = ramp to 50% then disable bridge
//  i_period      in   DWID  PWM period in clk cycles (same value given to bridge)
//  i_step        in   DWID  max hi_time change per update tick; 0 = unlimited
//  i_cmd         in   SWID  signed speed command, +max = full forward
//  i_cmd_valid   in   1     command valid
//  o_cmd_ready   out  1     command accepted when valid&&ready
//  o_hi_time     out  DWID  hi_time to bridge
//  o_enable      out  1     enable to bridge
//  o_tick        out  1     1-cycle pulse on each update tick
//  o_at_target   out  1     o_hi_time == current target
// BEHAVIOUR
//  Reset (synchronous, any state): state=OFF, cmd_reg=0, tick_cnt=0, pipeline=0.
//   All outputs are 0.
//  Tick: tick_cnt counts 0..i_period-1; o_tick=1 for the cycle tick_cnt==i_period-1, then wraps to 0.
//   If tick_cnt>=i_period-1 (period lowered mid-run), the counter wraps immediately.
//   For i_period<2, a tick occurs every cycle.
//  center = i_period>>1, half = center. Command saturation: -2^(SWID-1) becomes -(2^(SWID-1)-1).
//  Target pipeline, recomputed every cycle from cmd_reg and i_period:
//   S1: prod = cmd_sat * half (signed).
//   S2: target = center + (prod >>> (SWID-1)); arithmetic shift, rounds toward -inf;
//       clamped to [0, i_period].
//   An accepted command reaches target 2 cycles after acceptance.
//  Slew, applied only on tick cycles in TRACK/BRAKE:
//   if i_step==0 or |target-hi|<=i_step, hi=target;
//   else hi moves toward target by i_step.
//  States:
//   OFF:   o_hi_time<=center every cycle; o_enable=0; o_cmd_ready=1.
//          On i_run=1, go to TRACK next cycle with hi=center.
//   TRACK: o_enable=1; o_cmd_ready=1; slew toward target. On i_run=0, go to BRAKE.
//   BRAKE: o_enable=1; o_cmd_ready=0; target forced to center; slew on ticks.
//          In the cycle after hi==center is observed, go to OFF and set o_enable=0.
//          If i_run returns to 1, go back to TRACK with no jump in hi.
//  Handshake: cmd_reg<=i_cmd on valid&&ready. A command accepted in OFF is retained;
//   the ramp starts from center on entry to TRACK. No FIFO: a new command overwrites.
//  Simultaneous events: tick in the same cycle as command accept uses the old target
//   (2-cycle pipeline). i_run falling on a tick: that tick still slews toward the TRACK target.
//  All outputs are registered; o_at_target is registered compare of hi vs target.
//  Width: the slew difference is computed in DWID+1 bits, so there is no wrap at 0 or i_period.
// TESTING (DWID=16, SWID=8, i_period=100, i_step=5)
//  1. rst 3 cycles, i_run=1, cmd=0 -> outputs 0 during rst; then o_enable=1, o_hi_time=50,
//     o_at_target=1.
//  2. cmd=+127 accepted -> target 99; on ticks (every 100 clk) hi=55,60,...,95,99;
//     o_at_target after the 10th tick.
//  3. cmd=-128 -> saturated to -127, target 0; hi steps down by 5 per tick to 0;
//     no underflow past 0.
//  4. At hi=99, i_run=0 -> o_cmd_ready=0; hi=94,...,54,50; o_enable=0 one cycle after hi==50.
//  5. i_step=0, cmd=+64 -> hi jumps 50->75 at first tick after target settles (2 cycles).
//  6. rst asserted mid-ramp at hi=70 -> next cycle all outputs 0, state OFF;
//     after release hi=50, o_enable=0.

Source files
------------

// File: rtl/lap_duty_ramp.sv
// Command stage for the locked-anti-phase bridge: maps a signed speed command to a hi_time
// about mid-period, slew-limits it once per PWM period and sequences the bridge enable.
module lap_duty_ramp #(
  parameter int DWID = 32,
  parameter int SWID = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_run,
  input  logic [DWID-1:0] i_period,
  input  logic [DWID-1:0] i_step,
  input  logic [SWID-1:0] i_cmd,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  output logic [DWID-1:0] o_hi_time,
  output logic            o_enable,
  output logic            o_tick,
  output logic            o_at_target
);

  // state    | meaning
  // ST_OFF   | bridge disabled, hi_time parked at center, commands accepted
  // ST_TRACK | bridge enabled, hi_time slews toward commanded target
  // ST_BRAKE | bridge enabled, hi_time slews to center, commands refused
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRACK = 2'd1,
    ST_BRAKE = 2'd2
  } state_e;

  localparam int PWID = SWID + DWID + 1;
  localparam int TWID = DWID + 2;
  localparam logic [SWID-1:0] CMD_MIN = {1'b1, {(SWID-1){1'b0}}};

  state_e            state_q, state_d;
  logic [SWID-1:0]   cmd_q, cmd_d;
  logic [DWID-1:0]   tick_cnt_q, tick_cnt_d;
  logic signed [PWID-1:0] prod_q, prod_d;
  logic [DWID-1:0]   target_q, target_d;
  logic [DWID-1:0]   hi_q, hi_d;
  logic              enable_q, enable_d;
  logic              ready_q, ready_d;
  logic              tick_q, tick_d;
  logic              at_tgt_q, at_tgt_d;

  logic [DWID-1:0]        center;
  logic                   tick_now;
  logic                   accept;
  logic signed [SWID-1:0] cmd_sat;
  logic signed [PWID-1:0] cmd_ext;
  logic signed [PWID-1:0] half_ext;
  logic signed [PWID-1:0] prod_sh;
  logic signed [TWID-1:0] tgt_sum;
  logic [DWID-1:0]        tgt_eff;
  logic [DWID:0]          diff;
  logic [DWID:0]          mag;
  logic [DWID-1:0]        slewed;

  // Period tick and command handshake
  always_comb begin
    center     = i_period >> 1;
    tick_now   = (i_period < DWID'(2)) || (tick_cnt_q >= i_period - DWID'(1));
    tick_cnt_d = tick_now ? '0 : tick_cnt_q + DWID'(1);
    tick_d     = tick_now;
    accept     = i_cmd_valid && ready_q;
    cmd_d      = accept ? i_cmd : cmd_q;
  end

  // Target pipeline: symmetric saturation keeps +/- full scale equidistant from center
  always_comb begin
    cmd_sat  = (cmd_q == CMD_MIN) ? $signed(CMD_MIN + SWID'(1)) : $signed(cmd_q);
    cmd_ext  = PWID'(cmd_sat);
    half_ext = $signed({{(PWID-DWID){1'b0}}, center});
    prod_d   = cmd_ext * half_ext;

    prod_sh  = prod_q >>> (SWID-1);
    tgt_sum  = $signed({2'b00, center}) + $signed(prod_sh[TWID-1:0]);
    if (tgt_sum[TWID-1]) begin
      target_d = '0;
    end else if (tgt_sum > $signed({2'b00, i_period})) begin
      target_d = i_period;
    end else begin
      target_d = tgt_sum[DWID-1:0];
    end
  end

  // Slew: difference carried in DWID+1 bits so neither end of the range wraps
  always_comb begin
    tgt_eff = (state_q == ST_BRAKE) ? center : target_q;
    diff    = {1'b0, tgt_eff} - {1'b0, hi_q};
    mag     = diff[DWID] ? -diff : diff;
    if ((i_step == '0) || (mag <= {1'b0, i_step})) begin
      slewed = tgt_eff;
    end else if (diff[DWID]) begin
      slewed = hi_q - i_step;
    end else begin
      slewed = hi_q + i_step;
    end
  end

  // Next-state and registered outputs
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    case (state_q)
      ST_OFF: begin
        hi_d = center;
        if (i_run) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (tick_now) hi_d = slewed;
        if (!i_run) state_d = ST_BRAKE;
      end
      ST_BRAKE: begin
        if (tick_now) hi_d = slewed;
        if (i_run) begin
          state_d = ST_TRACK;
        end else if (hi_q == center) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        hi_d    = center;
      end
    endcase

    enable_d = (state_d != ST_OFF);
    ready_d  = (state_d != ST_BRAKE);
    at_tgt_d = (hi_d == ((state_d == ST_BRAKE) ? center : target_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      cmd_q      <= '0;
      tick_cnt_q <= '0;
      prod_q     <= '0;
      target_q   <= '0;
      hi_q       <= '0;
      enable_q   <= 1'b0;
      ready_q    <= 1'b0;
      tick_q     <= 1'b0;
      at_tgt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tick_cnt_q <= tick_cnt_d;
      prod_q     <= prod_d;
      target_q   <= target_d;
      hi_q       <= hi_d;
      enable_q   <= enable_d;
      ready_q    <= ready_d;
      tick_q     <= tick_d;
      at_tgt_q   <= at_tgt_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_hi_time   = hi_q;
  assign o_enable    = enable_q;
  assign o_tick      = tick_q;
  assign o_at_target = at_tgt_q;

endmodule
